// File: rtl/score_bcd_counter.sv
// score_bcd_counter: NDIG-digit packed-BCD up/down counter for score/timer display.
// Level inc/dec requests are edge-detected, so each rising edge gives one step.
// Synchronous clr and load are supported. Sticky ovf/unf flags record hits at the range limits.
// Optional macro SCORE_WRAP_EN: wrap at the limits instead of saturating.

// Per-digit step/clamp logic: one instance per BCD digit.
module score_bcd_digit (
  input  logic [3:0] d,
  input  logic [3:0] ld,
  input  logic       inc_en,
  input  logic       dec_en,
  output logic [3:0] d_inc,
  output logic [3:0] d_dec,
  output logic [3:0] ld_sat,
  output logic       is9,
  output logic       is0
);
  assign is9    = (d == 4'd9);
  assign is0    = (d == 4'd0);
  // A digit only moves when every lower digit is rolling over.
  assign d_inc  = !inc_en ? d : (is9 ? 4'd0 : d + 4'd1);
  assign d_dec  = !dec_en ? d : (is0 ? 4'd9 : d - 4'd1);
  // Non-decimal load nibbles are clamped so the decoder never sees them.
  assign ld_sat = (ld > 4'd9) ? 4'd9 : ld;
endmodule

module score_bcd_counter #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  input  logic              inc,
  input  logic              dec,
  output logic [4*NDIG-1:0] bcd,
  output logic              zero,
  output logic              ovf,
  output logic              unf
);
  logic              inc_q, dec_q;
  logic              inc_ev, dec_ev;
  logic [NDIG:0]     low9, low0;
  logic [NDIG-1:0]   is9, is0;
  logic [4*NDIG-1:0] bcd_inc, bcd_dec, ld_sat;
  logic              all9, all0;

  assign inc_ev = inc & ~inc_q;
  assign dec_ev = dec & ~dec_q;

  assign low9[0] = 1'b1;
  assign low0[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < NDIG; g++) begin : g_dig
      score_bcd_digit u_dig (
        .d      (bcd[4*g +: 4]),
        .ld     (load_val[4*g +: 4]),
        .inc_en (low9[g]),
        .dec_en (low0[g]),
        .d_inc  (bcd_inc[4*g +: 4]),
        .d_dec  (bcd_dec[4*g +: 4]),
        .ld_sat (ld_sat[4*g +: 4]),
        .is9    (is9[g]),
        .is0    (is0[g])
      );
      assign low9[g+1] = low9[g] & is9[g];
      assign low0[g+1] = low0[g] & is0[g];
    end
  endgenerate

  assign all9 = low9[NDIG];
  assign all0 = low0[NDIG];
  // zero is decoded straight from the registered count.
  assign zero = all0;

  // Count, flags and edge registers. The edge registers reset high so a held request makes no step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd   <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      inc_q <= 1'b1;
      dec_q <= 1'b1;
    end else begin
      inc_q <= inc;
      dec_q <= dec;
      if (clr) begin
        bcd <= '0;
        ovf <= 1'b0;
        unf <= 1'b0;
      end else if (load) begin
        bcd <= ld_sat;
        ovf <= 1'b0;
        unf <= 1'b0;
      end else if (inc_ev && !dec_ev) begin
        if (all9) ovf <= 1'b1;
`ifdef SCORE_WRAP_EN
        // At all-9s, every digit rolls to 0.
        bcd <= bcd_inc;
`else
        if (!all9) bcd <= bcd_inc;
`endif
      end else if (dec_ev && !inc_ev) begin
        if (all0) unf <= 1'b1;
`ifdef SCORE_WRAP_EN
        // At zero, every digit rolls to 9.
        bcd <= bcd_dec;
`else
        if (!all0) bcd <= bcd_dec;
`endif
      end
    end
  end
endmodule

// File: doc/score_bcd_counter.md
# score_bcd_counter

Multi-digit packed-BCD up/down counter for the game score and timer display. It edge-detects level increment and decrement requests, supports synchronous clear and parallel load, and saturates or wraps at the range limits. Each 4-bit digit output drives one BCD-to-seven-segment decoder directly, so every value it emits is in 0..9.

## Interface
Parameters:
- NDIG, 4: number of BCD digits (1..6); counting range is 0 to 10^NDIG-1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear; highest priority.
- load  in  1  synchronous parallel load of load_val.
- load_val  in  4*NDIG  packed BCD load value; digit 0 (units) in [3:0].
- inc  in  1  level increment request, already synchronised; one step per rising edge.
- dec  in  1  level decrement request, already synchronised; one step per rising edge.
- bcd  out  4*NDIG  registered packed BCD count; digit i in [4i+3:4i].
- zero  out  1  high when every digit of bcd is 0 (decoded from registered bcd).
- ovf  out  1  sticky flag, set on an increment at the maximum value.
- unf  out  1  sticky flag, set on a decrement at 0.

## Operation
- Edge detect:
  - Registers inc_q and dec_q sample inc and dec every cycle.
  - inc_ev = inc & ~inc_q; dec_ev = dec & ~dec_q.
- Per-cycle priority:
  1. clr: bcd=0; ovf and unf cleared.
  2. load: bcd=load_val; ovf and unf cleared. Any load digit >9 is stored as 9.
  3. inc_ev & dec_ev in the same cycle: no change.
  4. inc_ev only: increment.
  5. dec_ev only: decrement.
- clr and load still update inc_q and dec_q. An edge that coincides with clr or load is consumed and discarded.
- Increment, per digit:
  - Digit i steps when all lower digits are 9.
  - 9 becomes 0 with a carry; otherwise the digit adds 1.
- Decrement, per digit:
  - Digit i steps when all lower digits are 0.
  - 0 becomes 9 with a borrow; otherwise the digit subtracts 1.
- Limit behaviour:
  - Increment at all-9s: ovf←1.
  - Decrement at 0: unf←1.
  - bcd at the limit depends on configuration (see Configuration).
- Flags stay set until clr, load or rst.
- No internal state machine beyond the count, the edge registers and the flags. The design is fully synchronous apart from rst.

## Timing
- Reset values:
  - bcd=0, zero=1, ovf=0, unf=0.
  - inc_q=1, dec_q=1, so a request held high through reset release causes no step.
- Latency:
  - A rising edge of inc or dec sampled at clock edge k updates bcd, ovf and unf at edge k.
  - The new values are visible to the decoder for the whole cycle after k.
- zero tracks bcd in the same cycle, with no extra register stage.
- Rate limit: at most one step per input pulse. A request held high for N cycles gives exactly one step. A new step requires the input to go low for at least 1 cycle.
- rst asserted mid-operation forces the reset values immediately, with no wait for clk. The first edge after release behaves as if no request were pending.
- Every digit the block ever emits is 0..9, so the decoder's letter and dash codes never appear from this block.

## Configuration
- SCORE_WRAP_EN defined:
  - Increment at all-9s wraps to 0.
  - Decrement at 0 wraps to all-9s.
  - ovf and unf are still set.
- SCORE_WRAP_EN undefined:
  - bcd saturates and holds all-9s on increment, or 0 on decrement.
  - ovf and unf are still set.

## Test plan
- Reset with inc=1 held high, release rst, keep inc=1 for 5 cycles -> bcd=0x0000, zero=1. Drop inc for 1 cycle then raise it -> bcd=0x0001 at the first edge, zero=0.
- load=1 with load_val=0x0199, then one inc pulse -> bcd=0x0200. Then one dec pulse -> bcd=0x0199.
- load_val=0x9999, one inc pulse:
  - without SCORE_WRAP_EN -> bcd=0x9999, ovf=1.
  - with SCORE_WRAP_EN -> bcd=0x0000, ovf=1, zero=1.
- From bcd=0x0000, one dec pulse:
  - without SCORE_WRAP_EN -> bcd=0x0000, unf=1.
  - with SCORE_WRAP_EN -> bcd=0x9999, unf=1.
  - Then clr -> bcd=0, unf=0.
- From bcd=0x0042, rising inc and rising dec in the same cycle -> bcd stays 0x0042. Then load_val=0x0A3C -> bcd=0x0939.
- Assert rst asynchronously mid-cycle with bcd=0x0057 and ovf=1 -> bcd=0, ovf=0, zero=1 before the next clk edge.
